// File: rtl/apb_ctrl_pkg.sv
// Shared types, default widths and the slave-select decode helper for the
// APB master controller.
package apb_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int DEF_NUM_REQ        = 2;
    localparam int DEF_ADDR_W         = 8;
    localparam int DEF_DATA_W         = 8;
    localparam int DEF_SLV_W          = 2;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    // Widest slave-id field the decode helper supports.
    localparam int MAX_SLV_W = 4;
    localparam int MAX_SLV   = 1 << MAX_SLV_W;

    // One-hot slave select for a slave id; callers keep the low NUM_SLV bits.
    function automatic logic [MAX_SLV-1:0] slv_onehot(input logic [MAX_SLV_W-1:0] id);
        logic [MAX_SLV-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/apb_master_ctrl_rr_arbiter.sv
// Round-robin arbiter: first eligible requester at or above the pointer,
// wrapping around. The pointer moves past the winner on every grant.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0]   ptr;
    logic [NUM_REQ-1:0] elig;

    assign elig = req & ~mask;

    // Scan from the pointer, wrapping past NUM_REQ-1 back to 0.
    always_comb begin
        int j;
        grant_valid = 1'b0;
        grant_idx   = '0;
        j           = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!grant_valid && elig[j[IDX_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = j[IDX_W-1:0];
            end
        end
    end

    // Pointer advances to the requester after the winner.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (grant_valid) begin
            if (int'(grant_idx) == NUM_REQ - 1) ptr <= '0;
            else                                ptr <= grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master controller shared by NUM_REQ requesters: round-robin grant,
// MSB slave decode, IDLE/SETUP/ACCESS sequencing with wait states, and a
// one-cycle done pulse with read data back to the granted requester.
// Optional build macro APB_TIMEOUT_EN adds a wait-state timeout that aborts
// the transfer and flags err alongside done.
module apb_master_ctrl
    import apb_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int SLV_W          = DEF_SLV_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int NUM_SLV        = 1 << SLV_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rdata_out,
    output logic [NUM_REQ-1:0]        err,
    output logic [ADDR_W-1:0]         addr,
    output logic [DATA_W-1:0]         wdata,
    output logic                      write,
    output logic [NUM_SLV-1:0]        sel,
    output logic                      enable,
    input  logic [DATA_W-1:0]         rdata,
    input  logic                      ready
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    apb_state_t         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               write_q;
    logic [IDX_W-1:0]   gidx_q;
    logic [NUM_REQ-1:0] gidx_oh;
    logic [NUM_REQ-1:0] done_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [NUM_REQ-1:0] arb_req;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic               to_hit;
    logic [MAX_SLV-1:0] slv_oh;

    // Arbitrate only while idle so the pointer moves once per transfer;
    // the requester just completed is masked during its done cycle.
    assign arb_req = (state_q == IDLE) ? req : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (arb_req),
        .mask        (done_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign gidx_oh = NUM_REQ'(1) << gidx_q;
    assign slv_oh  = slv_onehot(MAX_SLV_W'(addr_q[ADDR_W-1 -: SLV_W]));

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]   wait_cnt;
    logic [NUM_REQ-1:0] err_q;

    // Wait-state counter: cleared while in SETUP, counts ready-low ACCESS cycles.
    always_ff @(posedge clk) begin
        if (reset)                              wait_cnt <= '0;
        else if (state_q == SETUP)              wait_cnt <= '0;
        else if (state_q == ACCESS && !ready)   wait_cnt <= wait_cnt + 1'b1;
    end

    // Abort on the ready-low cycle that brings the count to TIMEOUT_CYCLES.
    assign to_hit = (state_q == ACCESS) && !ready &&
                    (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // err pulses alongside done only for a timed-out transfer.
    always_ff @(posedge clk) begin
        if (reset)        err_q <= '0;
        else if (to_hit)  err_q <= gidx_oh;
        else              err_q <= '0;
    end

    assign err = err_q;
`else
    assign to_hit = 1'b0;
    assign err    = '0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: SETUP lasts one cycle, ACCESS holds until ready (or timeout).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (ready || to_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the winner's request at grant; capture completion data and pulse done.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            gidx_q  <= '0;
            done_q  <= '0;
            rdata_q <= '0;
        end else begin
            done_q <= '0;
            if (state_q == IDLE && grant_valid) begin
                addr_q  <= req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
                wdata_q <= req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
                write_q <= req_write[grant_idx];
                gidx_q  <= grant_idx;
            end
            if (state_q == ACCESS && (ready || to_hit)) begin
                done_q  <= gidx_oh;
                rdata_q <= ready ? rdata : '0;
            end
        end
    end

    // Bus outputs: driven only in SETUP/ACCESS, all zero while idle.
    always_comb begin
        sel    = '0;
        enable = 1'b0;
        addr   = '0;
        wdata  = '0;
        write  = 1'b0;
        if (state_q != IDLE) begin
            sel    = slv_oh[NUM_SLV-1:0];
            enable = (state_q == ACCESS);
            addr   = addr_q;
            wdata  = wdata_q;
            write  = write_q;
        end
    end

    assign done      = done_q;
    assign rdata_out = rdata_q;

endmodule
